// File: rtl/ysyx_22050612_pkg.sv
// Shared definitions for the NPC writeback unit:
// FSM state encoding, load funct3 codes and the default datapath width.
package ysyx_22050612_pkg;

    localparam int XLEN_DEF = 64;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_WRITE = 2'd2
    } wbu_state_e;

    localparam logic [2:0] LB  = 3'd0;
    localparam logic [2:0] LH  = 3'd1;
    localparam logic [2:0] LW  = 3'd2;
    localparam logic [2:0] LD  = 3'd3;
    localparam logic [2:0] LBU = 3'd4;
    localparam logic [2:0] LHU = 3'd5;
    localparam logic [2:0] LWU = 3'd6;

endpackage

// File: rtl/ysyx_22050612_load_ext.sv
// Load formatter: picks the addressed byte/half/word out of an aligned
// doubleword and sign- or zero-extends it; undefined funct3 yields zero.
module ysyx_22050612_load_ext
    import ysyx_22050612_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [2:0]      fmt_i,
    input  logic [2:0]      off_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [XLEN-1:0] data_o
);

    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w;

    // Slice the doubleword at the natural alignment of each access size
    always_comb begin
        b = rdata_i[{off_i, 3'b000} +: 8];
        h = rdata_i[{off_i[2:1], 4'b0000} +: 16];
        w = rdata_i[{off_i[2], 5'b00000} +: 32];
    end

    // Extend the selected slice according to funct3
    always_comb begin
        data_o = '0;
        unique case (fmt_i)
            LB:      data_o = {{(XLEN-8){b[7]}}, b};
            LH:      data_o = {{(XLEN-16){h[15]}}, h};
            LW:      data_o = {{(XLEN-32){w[31]}}, w};
            LD:      data_o = rdata_i;
            LBU:     data_o = {{(XLEN-8){1'b0}}, b};
            LHU:     data_o = {{(XLEN-16){1'b0}}, h};
            LWU:     data_o = {{(XLEN-32){1'b0}}, w};
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/ysyx_22050612_wbu.sv
// Writeback unit: retires one instruction per WRITE cycle, waits on LSU data
// for loads and flags RAW hazards against the single in-flight rd.
module ysyx_22050612_wbu
    import ysyx_22050612_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic [ADDR_WIDTH-1:0] ex_rd,
    input  logic                  ex_rd_wen,
    input  logic [XLEN-1:0]       ex_result,
    input  logic                  ex_is_load,
    input  logic [2:0]            ex_ld_fmt,
    input  logic                  lsu_rvalid,
    input  logic [XLEN-1:0]       lsu_rdata,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [XLEN-1:0]       rf_wdata,
    output logic                  commit,
    input  logic [ADDR_WIDTH-1:0] id_rs1,
    input  logic [ADDR_WIDTH-1:0] id_rs2,
    output logic                  id_stall
);

    wbu_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] rd_q;
    logic                  rd_wen_q;
    logic [2:0]            fmt_q;
    logic [2:0]            off_q;
    logic                  rf_wen_q, rf_wen_d;
    logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]       rf_wdata_q, rf_wdata_d;
    logic                  commit_q, commit_d;
    logic [XLEN-1:0]       ld_val;
    logic                  accept;
    logic                  rd_live;

    ysyx_22050612_load_ext #(.XLEN(XLEN)) u_ext (
        .fmt_i   (fmt_q),
        .off_i   (off_q),
        .rdata_i (lsu_rdata),
        .data_o  (ld_val)
    );

    assign ex_ready = (state_q == S_IDLE) || (state_q == S_WRITE);
    assign accept   = ex_valid && ex_ready;
    assign rd_live  = (state_q != S_IDLE) && rd_wen_q && (rd_q != '0);
    assign id_stall = rd_live && ((id_rs1 == rd_q) || (id_rs2 == rd_q));

    assign rf_wen   = rf_wen_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign commit   = commit_q;

    // Next state and the write-port values for the upcoming WRITE cycle
    always_comb begin
        state_d    = state_q;
        rf_wen_d   = 1'b0;
        rf_waddr_d = '0;
        rf_wdata_d = '0;
        commit_d   = 1'b0;
        unique case (state_q)
            S_IDLE, S_WRITE: begin
                if (accept) begin
                    if (ex_is_load) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d    = S_WRITE;
                        commit_d   = 1'b1;
                        rf_wen_d   = ex_rd_wen && (ex_rd != '0);
                        rf_waddr_d = ex_rd;
                        rf_wdata_d = ex_result;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (lsu_rvalid) begin
                    state_d    = S_WRITE;
                    commit_d   = 1'b1;
                    rf_wen_d   = rd_wen_q && (rd_q != '0);
                    rf_waddr_d = rd_q;
                    rf_wdata_d = ld_val;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state and registered write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            commit_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rf_wen_q   <= rf_wen_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            commit_q   <= commit_d;
        end
    end

    // Capture the accepted instruction's fields for later writeback
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q     <= '0;
            rd_wen_q <= 1'b0;
            fmt_q    <= 3'd0;
            off_q    <= 3'd0;
        end else if (accept) begin
            rd_q     <= ex_rd;
            rd_wen_q <= ex_rd_wen;
            fmt_q    <= ex_ld_fmt;
            off_q    <= ex_result[2:0];
        end
    end

endmodule

// File: tb/tb_ysyx_22050612_wbu.sv
// Self-checking bench for the writeback unit: ALU vector table,
// directed load/hazard/reset sequences and randomized traffic.
module tb_ysyx_22050612_wbu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic        ex_ready;
    logic [4:0]  ex_rd;
    logic        ex_rd_wen;
    logic [63:0] ex_result;
    logic        ex_is_load;
    logic [2:0]  ex_ld_fmt;
    logic        lsu_rvalid;
    logic [63:0] lsu_rdata;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic        commit;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_stall;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    ysyx_22050612_wbu #(.XLEN(64), .ADDR_WIDTH(5)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .ex_rd      (ex_rd),
        .ex_rd_wen  (ex_rd_wen),
        .ex_result  (ex_result),
        .ex_is_load (ex_is_load),
        .ex_ld_fmt  (ex_ld_fmt),
        .lsu_rvalid (lsu_rvalid),
        .lsu_rdata  (lsu_rdata),
        .rf_wen     (rf_wen),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .commit     (commit),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_stall   (id_stall)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference load formatter, from access size and signedness
    function automatic logic [63:0] ref_load(input logic [2:0] f,
                                             input logic [2:0] off,
                                             input logic [63:0] d);
        int n, base;
        logic [63:0] v, m;
        if (f == 3'd7) return 64'd0;
        n = 1 << f[1:0];
        base = (int'(off) / n) * n;
        v = d >> (base * 8);
        if (n == 8) return v;
        m = (64'd1 << (n * 8)) - 64'd1;
        v = v & m;
        if (!f[2] && v[n*8-1]) v = v | ~m;
        return v;
    endfunction

    function automatic logic ref_stall(input logic [4:0] rd, input logic w,
                                       input logic [4:0] r1,
                                       input logic [4:0] r2);
        return w && (rd != 5'd0) && (r1 == rd || r2 == rd);
    endfunction

    task automatic idle_inputs();
        ex_valid   = 1'b0;
        ex_rd      = 5'd0;
        ex_rd_wen  = 1'b0;
        ex_result  = 64'd0;
        ex_is_load = 1'b0;
        ex_ld_fmt  = 3'd0;
        lsu_rvalid = 1'b0;
        lsu_rdata  = 64'd0;
    endtask

    // One instruction from accept to back-to-idle, checked every cycle
    task automatic run_op(input logic ld, input logic [4:0] rd,
                          input logic w, input logic [63:0] res,
                          input logic [2:0] f, input logic [63:0] d,
                          input int k, input logic [4:0] r1,
                          input logic [4:0] r2, input logic stray);
        logic [63:0] exp_d;
        logic        exp_s;
        exp_d = ld ? ref_load(f, res[2:0], d) : res;
        exp_s = ref_stall(rd, w, r1, r2);
        id_rs1 = r1;
        id_rs2 = r2;
        chk("ready_before", ex_ready, 1);
        chk("stall_idle", id_stall, 0);
        ex_valid   = 1'b1;
        ex_rd      = rd;
        ex_rd_wen  = w;
        ex_result  = res;
        ex_is_load = ld;
        ex_ld_fmt  = f;
        lsu_rvalid = stray;
        lsu_rdata  = ~d;
        tick();
        ex_valid   = 1'b0;
        lsu_rvalid = 1'b0;
        if (ld) begin
            for (int i = 0; i < k; i++) begin
                chk("ready_wait", ex_ready, 0);
                chk("commit_wait", commit, 0);
                chk("stall_wait", id_stall, exp_s);
                if (i == k - 1) begin
                    lsu_rvalid = 1'b1;
                    lsu_rdata  = d;
                end
                tick();
                lsu_rvalid = 1'b0;
                lsu_rdata  = 64'd0;
            end
        end
        chk("commit_wr", commit, 1);
        chk("wen_wr", rf_wen, w && rd != 0);
        chk("waddr_wr", rf_waddr, rd);
        chk("wdata_wr", rf_wdata, exp_d);
        chk("stall_wr", id_stall, exp_s);
        chk("ready_wr", ex_ready, 1);
        tick();
        chk("commit_after", commit, 0);
        chk("wen_after", rf_wen, 0);
        chk("stall_after", id_stall, 0);
    endtask

    typedef struct {
        logic [4:0]  rd;
        logic        w;
        logic [63:0] res;
        logic        exp_wen;
        logic [63:0] exp_data;
    } alu_vec_t;

    alu_vec_t tbl[5];

    initial begin
        tbl[0] = '{5'd1, 1'b1, 64'h11, 1'b1, 64'h11};
        tbl[1] = '{5'd2, 1'b1, 64'h22, 1'b1, 64'h22};
        tbl[2] = '{5'd3, 1'b1, 64'h33, 1'b1, 64'h33};
        tbl[3] = '{5'd0, 1'b1, 64'hDEAD, 1'b0, 64'hDEAD};
        tbl[4] = '{5'd9, 1'b0, 64'hFFFF_0000_1234_5678, 1'b0,
                   64'hFFFF_0000_1234_5678};

        idle_inputs();
        id_rs1 = 5'd0;
        id_rs2 = 5'd0;
        rst_n  = 1'b0;
        repeat (3) tick();
        chk("rst_wen", rf_wen, 0);
        chk("rst_waddr", rf_waddr, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_commit", commit, 0);
        chk("rst_stall", id_stall, 0);
        chk("rst_ready", ex_ready, 1);
        rst_n = 1'b1;
        tick();

        run_op(0, 5'd5, 1, 64'h1234, 3'd0, 64'd0, 0, 5'd0, 5'd0, 0);

        // back-to-back ALU ops, one write per cycle in order
        for (int i = 0; i < 5; i++) begin
            chk("b2b_ready", ex_ready, 1);
            ex_valid  = 1'b1;
            ex_rd     = tbl[i].rd;
            ex_rd_wen = tbl[i].w;
            ex_result = tbl[i].res;
            tick();
            chk("b2b_commit", commit, 1);
            chk("b2b_wen", rf_wen, tbl[i].exp_wen);
            chk("b2b_waddr", rf_waddr, tbl[i].rd);
            chk("b2b_wdata", rf_wdata, tbl[i].exp_data);
        end
        idle_inputs();
        tick();
        chk("b2b_end_commit", commit, 0);

        run_op(1, 5'd7, 1, 64'h1003, 3'd0, 64'h0000_0000_8000_0000, 4,
               5'd0, 5'd0, 0);
        chk("lb_val", rf_wdata, 0);
        run_op(1, 5'd7, 1, 64'h1003, 3'd4, 64'h0000_0000_8000_0000, 4,
               5'd1, 5'd7, 1);
        run_op(0, 5'd0, 1, 64'hDEAD, 3'd0, 64'd0, 0, 5'd0, 5'd0, 0);
        run_op(1, 5'd12, 1, 64'h2006, 3'd1, 64'h8123_4567_89AB_CDEF, 2,
               5'd12, 5'd3, 0);
        run_op(1, 5'd13, 1, 64'h2005, 3'd2, 64'h8123_4567_89AB_CDEF, 1,
               5'd4, 5'd4, 0);
        run_op(1, 5'd14, 1, 64'h2000, 3'd7, 64'h8123_4567_89AB_CDEF, 1,
               5'd14, 5'd0, 0);

        // reset while waiting on the LSU drops the load
        ex_valid = 1'b1; ex_rd = 5'd8; ex_rd_wen = 1'b1;
        ex_is_load = 1'b1; ex_ld_fmt = 3'd3; ex_result = 64'h3000;
        tick();
        idle_inputs();
        tick();
        chk("rst_mid_ready0", ex_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ready", ex_ready, 1);
        chk("rst_mid_commit", commit, 0);
        tick();
        rst_n = 1'b1;
        lsu_rvalid = 1'b1;
        lsu_rdata = 64'hAAAA;
        tick();
        lsu_rvalid = 1'b0;
        chk("stray_commit", commit, 0);
        chk("stray_wen", rf_wen, 0);
        chk("stray_ready", ex_ready, 1);
        tick();
        chk("stray_commit2", commit, 0);

        // randomized traffic against the reference model
        for (int t = 0; t < 60; t++) begin
            run_op(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                   1'($urandom_range(0, 1)), {$urandom, $urandom},
                   3'($urandom_range(0, 7)), {$urandom, $urandom},
                   $urandom_range(1, 4), 5'($urandom_range(0, 31)),
                   5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
